// File: rtl/hist_pkg.sv
// Shared types and defaults for the histogram result collector.
package hist_pkg;

   localparam int unsigned FREQ_W = 16;
   localparam int unsigned MODE_W = 16;

   localparam int unsigned DEFAULT_DEPTH     = 16;
   localparam int unsigned DEFAULT_FRAME_LEN = 64;

   // Packed so that it lays out directly as the output word {mode, frequency}.
   typedef struct packed {
      logic [MODE_W-1:0] mode;
      logic [FREQ_W-1:0] frequency;
   } hist_pair_t;

endpackage

// File: rtl/hist_sync_fifo.sv
// Single-clock FIFO with a registered full_n flag and combinational empty.
// Writes presented while full_n_o is low are dropped and flagged on ovf_o.
module hist_sync_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             wr_i,
   output logic             full_n_o,
   input  logic             rd_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic             ovf_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             full_n_q;
   logic             wr_acc, rd_acc;

   assign wr_acc   = wr_i & full_n_q;
   assign rd_acc   = rd_i & ~empty_o;
   assign empty_o  = (count_q == '0);
   assign full_n_o = full_n_q;
   assign rdata_o  = mem_q[rd_ptr_q];
   assign ovf_o    = wr_i & ~full_n_q;

   // Occupancy after this edge; full_n is derived from it so it is ready a cycle early.
   always_comb begin
      count_d = count_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
   end

   // Storage array, no reset needed since pointers define validity.
   always_ff @(posedge clk_i) begin
      if (!rst_i && wr_acc) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers, occupancy and the registered full_n flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_n_q <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q  <= count_d;
         full_n_q <= (count_d < (AW+1)'(DEPTH));
      end
   end

endmodule

// File: rtl/hist_result_collector.sv
// Pairs the histogram core's frequency and mode streams into 32-bit words on a
// valid/ready stream, marking the last pair of every FRAME_LEN-pair frame.
// Optional feature macro: HIST_COLLECT_STATS_EN adds pair_count and stall_cycles.
module hist_result_collector
   import hist_pkg::*;
#(
   parameter int unsigned DEPTH     = DEFAULT_DEPTH,
   parameter int unsigned FRAME_LEN = DEFAULT_FRAME_LEN
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst,
   input  logic [FREQ_W-1:0]        frequency_in_V_V_din,
   input  logic                     frequency_in_V_V_write,
   output logic                     frequency_in_V_V_full_n,
   input  logic [MODE_W-1:0]        mode_in_V_V_din,
   input  logic                     mode_in_V_V_write,
   output logic                     mode_in_V_V_full_n,
   output logic [MODE_W+FREQ_W-1:0] m_tdata,
   output logic                     m_tvalid,
   input  logic                     m_tready,
   output logic                     m_tlast,
   output logic [15:0]              frame_count,
   output logic                     overflow_err
`ifdef HIST_COLLECT_STATS_EN
   ,
   output logic [31:0]              pair_count,
   output logic [31:0]              stall_cycles
`endif
);

   localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

   logic              freq_empty, mode_empty;
   logic              freq_ovf, mode_ovf;
   logic [FREQ_W-1:0] freq_head;
   logic [MODE_W-1:0] mode_head;
   logic              load;
   logic              handshake;

   hist_pair_t        out_q;
   logic              out_valid_q;
   logic              out_last_q;
   logic [CNT_W-1:0]  pair_idx_q;
   logic [15:0]       frame_cnt_q;
   logic              ovf_q;

   // Pop both heads together whenever the output register is free or draining.
   assign load      = ~freq_empty & ~mode_empty & (~out_valid_q | m_tready);
   assign handshake = out_valid_q & m_tready;

   hist_sync_fifo #(
      .WIDTH (FREQ_W),
      .DEPTH (DEPTH)
   ) u_freq_fifo (
      .clk_i    (ap_clk),
      .rst_i    (ap_rst),
      .wdata_i  (frequency_in_V_V_din),
      .wr_i     (frequency_in_V_V_write),
      .full_n_o (frequency_in_V_V_full_n),
      .rd_i     (load),
      .rdata_o  (freq_head),
      .empty_o  (freq_empty),
      .ovf_o    (freq_ovf)
   );

   hist_sync_fifo #(
      .WIDTH (MODE_W),
      .DEPTH (DEPTH)
   ) u_mode_fifo (
      .clk_i    (ap_clk),
      .rst_i    (ap_rst),
      .wdata_i  (mode_in_V_V_din),
      .wr_i     (mode_in_V_V_write),
      .full_n_o (mode_in_V_V_full_n),
      .rd_i     (load),
      .rdata_o  (mode_head),
      .empty_o  (mode_empty),
      .ovf_o    (mode_ovf)
   );

   // Output register and in-frame pair index; holds steady while stalled.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         pair_idx_q  <= '0;
      end else if (load) begin
         out_q.mode      <= mode_head;
         out_q.frequency <= freq_head;
         out_valid_q     <= 1'b1;
         out_last_q      <= (pair_idx_q == LAST_IDX);
         pair_idx_q      <= (pair_idx_q == LAST_IDX) ? '0 : pair_idx_q + CNT_W'(1);
      end else if (m_tready) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end
   end

   // Completed-frame counter and sticky overflow flag.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         frame_cnt_q <= '0;
         ovf_q       <= 1'b0;
      end else begin
         if (handshake && out_last_q) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (freq_ovf || mode_ovf)    ovf_q       <= 1'b1;
      end
   end

   assign m_tdata      = out_q;
   assign m_tvalid     = out_valid_q;
   assign m_tlast      = out_last_q;
   assign frame_count  = frame_cnt_q;
   assign overflow_err = ovf_q;

`ifdef HIST_COLLECT_STATS_EN
   logic [31:0] pair_cnt_q;
   logic [31:0] stall_cnt_q;

   // Handshaken pairs (wrapping) and stalled cycles (saturating).
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         pair_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (handshake) pair_cnt_q <= pair_cnt_q + 32'd1;
         if (out_valid_q && !m_tready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign pair_count   = pair_cnt_q;
   assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hist_result_collector.sv
// Self-checking bench for hist_result_collector: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_hist_result_collector;

   localparam int unsigned DEPTH     = 16;
   localparam int unsigned FRAME_LEN = 64;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic [15:0] f_din, m_din;
   logic        f_write, m_write;
   logic        f_full_n, m_full_n;
   logic [31:0] m_tdata;
   logic        m_tvalid, m_tready, m_tlast;
   logic [15:0] frame_count;
   logic        overflow_err;
`ifdef HIST_COLLECT_STATS_EN
   logic [31:0] pair_count, stall_cycles;
`endif

   always #5 ap_clk = ~ap_clk;

   hist_result_collector #(
      .DEPTH     (DEPTH),
      .FRAME_LEN (FRAME_LEN)
   ) dut (
      .ap_clk                  (ap_clk),
      .ap_rst                  (ap_rst),
      .frequency_in_V_V_din    (f_din),
      .frequency_in_V_V_write  (f_write),
      .frequency_in_V_V_full_n (f_full_n),
      .mode_in_V_V_din         (m_din),
      .mode_in_V_V_write       (m_write),
      .mode_in_V_V_full_n      (m_full_n),
      .m_tdata                 (m_tdata),
      .m_tvalid                (m_tvalid),
      .m_tready                (m_tready),
      .m_tlast                 (m_tlast),
      .frame_count             (frame_count),
      .overflow_err            (overflow_err)
`ifdef HIST_COLLECT_STATS_EN
      ,
      .pair_count              (pair_count),
      .stall_cycles            (stall_cycles)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: buffer contents as queues plus the output slot.
   logic [15:0] fq[$];
   logic [15:0] mq[$];
   logic        mod_valid, mod_last, mod_ffn, mod_mfn, mod_ovf;
   logic [31:0] mod_data;
   int          mod_idx;
   logic [15:0] mod_frames;
   logic [31:0] mod_pairs, mod_stall;

   // Words and tlast positions seen on DUT handshakes.
   logic [31:0] got_words[$];
   int          last_pos[$];
   int          dut_hs;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      logic        ld;
      logic [15:0] f, m;
      if (ap_rst) begin
         fq.delete();
         mq.delete();
         mod_valid  = 1'b0;
         mod_last   = 1'b0;
         mod_data   = '0;
         mod_idx    = 0;
         mod_frames = '0;
         mod_ovf    = 1'b0;
         mod_ffn    = 1'b0;
         mod_mfn    = 1'b0;
         mod_pairs  = '0;
         mod_stall  = '0;
      end else begin
         if (mod_valid && m_tready) begin
            mod_pairs = mod_pairs + 1;
            if (mod_last) mod_frames = mod_frames + 16'd1;
         end
         if (mod_valid && !m_tready && mod_stall != 32'hffff_ffff) mod_stall = mod_stall + 1;
         ld = (fq.size() > 0) && (mq.size() > 0) && (!mod_valid || m_tready);
         if (ld) begin
            f         = fq.pop_front();
            m         = mq.pop_front();
            mod_data  = {m, f};
            mod_last  = (mod_idx == FRAME_LEN - 1);
            mod_idx   = mod_last ? 0 : mod_idx + 1;
            mod_valid = 1'b1;
         end else if (m_tready) begin
            mod_valid = 1'b0;
            mod_last  = 1'b0;
         end
         if (f_write) begin
            if (mod_ffn) fq.push_back(f_din);
            else         mod_ovf = 1'b1;
         end
         if (m_write) begin
            if (mod_mfn) mq.push_back(m_din);
            else         mod_ovf = 1'b1;
         end
         mod_ffn = (fq.size() < DEPTH);
         mod_mfn = (mq.size() < DEPTH);
      end
   endtask

   task automatic check_outputs();
      check_eq("tvalid", {31'd0, m_tvalid}, {31'd0, mod_valid});
      check_eq("freq_full_n", {31'd0, f_full_n}, {31'd0, mod_ffn});
      check_eq("mode_full_n", {31'd0, m_full_n}, {31'd0, mod_mfn});
      check_eq("frame_count", {16'd0, frame_count}, {16'd0, mod_frames});
      check_eq("overflow_err", {31'd0, overflow_err}, {31'd0, mod_ovf});
      if (mod_valid) begin
         check_eq("tdata", m_tdata, mod_data);
         check_eq("tlast", {31'd0, m_tlast}, {31'd0, mod_last});
      end
`ifdef HIST_COLLECT_STATS_EN
      check_eq("pair_count", pair_count, mod_pairs);
      check_eq("stall_cycles", stall_cycles, mod_stall);
`endif
   endtask

   // Drive one cycle of inputs, advance DUT and model together, then compare.
   task automatic cyc(input logic fw, input logic [15:0] fd, input logic mw,
                      input logic [15:0] md, input logic rdy, input logic rst);
      ap_rst   = rst;
      f_write  = fw;
      f_din    = fd;
      m_write  = mw;
      m_din    = md;
      m_tready = rdy;
      if (!rst && m_tvalid && m_tready) begin
         dut_hs++;
         got_words.push_back(m_tdata);
         if (m_tlast) last_pos.push_back(dut_hs);
      end
      @(posedge ap_clk);
      model_step();
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
      check_eq("rst_tdata", m_tdata, 32'd0);
      check_eq("rst_tlast", {31'd0, m_tlast}, 32'd0);
      cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      got_words.delete();
      last_pos.delete();
      dut_hs = 0;
   endtask

   initial begin
      int written, hs_before;
      logic rdy;
      dut_hs = 0;
      ap_rst = 1'b1;
      f_write = 1'b0;
      m_write = 1'b0;
      f_din = '0;
      m_din = '0;
      m_tready = 1'b0;
      #1;

      // Interleaved writes, first-word latency and ordering.
      do_reset();
      cyc(1'b1, 16'h0010, 1'b1, 16'h0100, 1'b1, 1'b0);
      check_eq("lat_edge_t", {31'd0, m_tvalid}, 32'd0);
      cyc(1'b1, 16'h0011, 1'b1, 16'h0101, 1'b1, 1'b0);
      check_eq("lat_edge_t1", {31'd0, m_tvalid}, 32'd1);
      check_eq("first_word", m_tdata, 32'h0100_0010);
      for (int i = 2; i < 4; i++) cyc(1'b1, 16'(16'h0010 + i), 1'b1, 16'(16'h0100 + i), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      check_eq("t1_count", got_words.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < got_words.size()) check_eq("t1_word", got_words[i], 32'h0100_0010 + i * 32'h0001_0001);
      end

      // Skew: frequency runs ahead, nothing emitted until mode arrives.
      got_words.delete();
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 16'(16'h0020 + i), 1'b0, '0, 1'b1, 1'b0);
         check_eq("skew_idle", {31'd0, m_tvalid}, 32'd0);
      end
      for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 16'(16'h0200 + i), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      check_eq("t2_count", got_words.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < got_words.size()) check_eq("t2_word", got_words[i], 32'h0200_0020 + i * 32'h0001_0001);
      end

      // Backpressure: 17 pairs fill register plus both buffers, 18th overflows.
      got_words.delete();
      for (int i = 0; i < 17; i++) cyc(1'b1, 16'(16'h3000 + i), 1'b1, 16'(16'h4000 + i), 1'b0, 1'b0);
      check_eq("bp_full_n_f", {31'd0, f_full_n}, 32'd0);
      check_eq("bp_full_n_m", {31'd0, m_full_n}, 32'd0);
      check_eq("bp_head", m_tdata, 32'h4000_3000);
      cyc(1'b1, 16'hdead, 1'b1, 16'hbeef, 1'b0, 1'b0);
      check_eq("bp_ovf", {31'd0, overflow_err}, 32'd1);
      for (int i = 0; i < 25; i++) cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      check_eq("bp_drain_count", got_words.size(), 17);

      // Framing: 128 pairs with tready toggling.
      do_reset();
      written = 0;
      rdy = 1'b1;
      for (int c = 0; c < 2000 && written < 128; c++) begin
         if (mod_ffn && mod_mfn) begin
            cyc(1'b1, 16'(written), 1'b1, 16'(16'h8000 + written), rdy, 1'b0);
            written++;
         end else begin
            cyc(1'b0, '0, 1'b0, '0, rdy, 1'b0);
         end
         rdy = ~rdy;
      end
      for (int i = 0; i < 300; i++) begin
         cyc(1'b0, '0, 1'b0, '0, rdy, 1'b0);
         rdy = ~rdy;
      end
      check_eq("frame_written", written, 128);
      check_eq("frame_hs", dut_hs, 128);
      check_eq("frame_count2", {16'd0, frame_count}, 32'd2);
      check_eq("tlast_count", last_pos.size(), 2);
      if (last_pos.size() == 2) begin
         check_eq("tlast_pos0", last_pos[0], 64);
         check_eq("tlast_pos1", last_pos[1], 128);
      end

      // Reset mid-operation with pairs buffered and the output valid.
      do_reset();
      for (int i = 0; i < 6; i++) cyc(1'b1, 16'(16'h5000 + i), 1'b1, 16'(16'h6000 + i), 1'b0, 1'b0);
      check_eq("pre_rst_valid", {31'd0, m_tvalid}, 32'd1);
      cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      check_eq("post_rst_valid", {31'd0, m_tvalid}, 32'd0);
      check_eq("post_rst_full_n", {31'd0, f_full_n}, 32'd1);
      check_eq("post_rst_frames", {16'd0, frame_count}, 32'd0);
      hs_before = dut_hs;
      for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      check_eq("no_stale", dut_hs - hs_before, 0);

      // Random traffic with occasional resets and overflow attempts.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         cyc(($urandom_range(0, 99) < 55), 16'($urandom), ($urandom_range(0, 99) < 55),
             16'($urandom), ($urandom_range(0, 99) < 45), ($urandom_range(0, 499) == 0));
      end

`ifdef HIST_COLLECT_STATS_EN
      // Ten pairs with exactly three stalled cycles.
      do_reset();
      for (int i = 0; i < 10; i++) cyc(1'b1, 16'(i), 1'b1, 16'(i), !(i >= 3 && i <= 5), 1'b0);
      for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      check_eq("stats_pairs", pair_count, 32'd10);
      check_eq("stats_stall", stall_cycles, 32'd3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hist_result_collector.md
# hist_result_collector

Receive-side endpoint for the histogram core's two output streams, frequency and mode. It sinks both ap_fifo-style write interfaces (din/full_n/write) into independent buffers and pairs the entries in order. Each pair is emitted as one 32-bit word on a valid/ready stream toward the host/DMA path, with a last marker closing every frame of FRAME_LEN pairs.

## Interface
- DEPTH, 16, entries per input buffer; power of two, ≥ 2
- FRAME_LEN, 64, pairs per output frame; ≥ 1
- ap_clk  in  1  sole clock, rising edge
- ap_rst  in  1  synchronous, active-high reset
- frequency_in_V_V_din  in  16  frequency word from histogram core
- frequency_in_V_V_write  in  1  frequency write strobe
- frequency_in_V_V_full_n  out  1  frequency buffer can accept
- mode_in_V_V_din  in  16  mode (bin index) word
- mode_in_V_V_write  in  1  mode write strobe
- mode_in_V_V_full_n  out  1  mode buffer can accept
- m_tdata  out  32  {mode[15:0], frequency[15:0]}
- m_tvalid  out  1  output word valid
- m_tready  in  1  downstream accepts
- m_tlast  out  1  final pair of current frame
- frame_count  out  16  completed frames, wraps at 2^16
- overflow_err  out  1  sticky: write attempted while full_n low

## Operation
- Each input has its own FIFO of DEPTH×16. A write is accepted on a rising edge when write=1 and full_n=1.
- A write with full_n=0 is dropped: buffer contents are unchanged and overflow_err is set. overflow_err clears only on ap_rst.
- Pairing: the head of the frequency FIFO and the head of the mode FIFO are popped together. A pop happens only when both FIFOs are non-empty.
- Output register is one stage. A load (pop) occurs when both FIFOs are non-empty and (m_tvalid=0 or m_tready=1). This gives full throughput of 1 pair/cycle.
- m_tdata, m_tvalid and m_tlast are held stable while m_tvalid=1 and m_tready=0.
- Pair counter runs 0..FRAME_LEN-1 and advances on each load.
- m_tlast=1 on the word loaded while the counter is FRAME_LEN-1. The counter then wraps to 0.
- frame_count increments on the handshake (m_tvalid & m_tready) of a word with m_tlast=1.
- Skew is allowed: one stream may run up to DEPTH entries ahead of the other. Pairing remains strictly in arrival order.
- Reset mid-operation: both FIFOs are flushed, all counters are zeroed, and the in-flight output word is discarded.
- Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, frame_count=0, overflow_err=0, both full_n=0 while ap_rst is high.

## Timing
- full_n is registered, computed from next occupancy. It reads 1 from the first edge after ap_rst deasserts.
- full_n drops in the cycle after the write that fills the buffer.
- A write and a pop at the same edge on a full buffer: the write is rejected (full_n was 0), and full_n returns to 1 on the next cycle.
- Latency: when both words are written at edge t into empty buffers, m_tvalid=1 after edge t+1.
- Backpressure: with m_tready=0, at most DEPTH+1 pairs are held. full_n deasserts once a buffer holds DEPTH entries.
- Simultaneous write and pop on the same buffer: occupancy is unchanged.

## Configuration
- HIST_COLLECT_STATS_EN defined: adds two outputs.
  - pair_count (32): total handshaken pairs, wraps.
  - stall_cycles (32): cycles with m_tvalid=1 and m_tready=0, saturating at 2^32-1.
  - Both reset to 0 on ap_rst.
- Not defined: these ports and their counters are absent; all other behaviour is identical.

## Structure
- Shared package hist_pkg holds:
  - FREQ_W=16 and MODE_W=16;
  - typedef hist_pair_t = struct {mode, frequency};
  - the default DEPTH and FRAME_LEN constants.
- Sub-module hist_sync_fifo is a single-clock FIFO with registered full_n and combinational empty, parameterised on width and depth. It is instantiated twice, once per input stream.
- Pairing/output register, frame counter and error flag live in the top.

## Test plan
- Reset then 4 interleaved writes of freq=0x0010+i and mode=0x0100+i with m_tready=1 -> m_tdata 0x01000010..0x01030013 in order; first m_tvalid two edges after first write.
- Write 5 frequency words with no mode words, then 5 mode words -> no output until the first mode write; then 5 correctly paired words.
- Hold m_tready=0 and write 17 pairs (DEPTH=16):
  - the 1st pair is in the output register;
  - full_n falls after the 17th write;
  - an 18th write is dropped and overflow_err=1.
  - Releasing m_tready then yields exactly 17 words.
- Stream 128 pairs with FRAME_LEN=64 and m_tready toggling 1/0 -> m_tlast only on pairs 64 and 128; frame_count=2; tdata stable during stalls.
- Assert ap_rst for one cycle with 6 pairs buffered and m_tvalid=1 -> next cycle m_tvalid=0, full_n=1, frame_count=0, and no stale data is emitted afterwards.
- With HIST_COLLECT_STATS_EN, run 10 pairs with 3 stall cycles -> pair_count=10, stall_cycles=3.
